qpu_ifu_fetch: RTL and testbench
================================

Name: qpu_ifu_fetch

Overview:
Instruction fetch front-end of the QPU IFU. It owns the fetch PC and issues single-outstanding ICB read commands to the ITCM controller. Returned 64-bit instruction words, tagged with their PC, go into a 2-entry instruction buffer that the decode stage drains through a valid/ready handshake. It supports redirect (branch/flush) with squash of in-flight responses, and a halt input that stops new fetches.

Parameters:
AW, 16, ITCM byte-address width; matches `QPU_ITCM_ADDR_WIDTH.
DW, 64, instruction word / ITCM data width; matches `QPU_ITCM_DATA_WIDTH.
MW, 8, write-mask width, DW/8.
RESET_PC, 0, fetch PC after reset; bits [2:0] ignored.

Ports:
clk  in  1  core clock; single clock domain.
rst_n  in  1  asynchronous, active-low reset.
redirect_valid  in  1  redirect PC this cycle; one-cycle pulse.
redirect_pc  in  AW  redirect target.
fetch_halt  in  1  level; blocks issue of new commands.
ifu_idle  out  1  no pending or outstanding ITCM transaction.
ifu_icb_cmd_valid  out  1  ICB command valid.
ifu_icb_cmd_ready  in  1  ICB command ready.
ifu_icb_cmd_addr  out  AW  word-aligned fetch address.
ifu_icb_cmd_read  out  1  constant 1.
ifu_icb_cmd_wdata  out  DW  constant 0.
ifu_icb_cmd_wmask  out  MW  constant 0.
ifu_icb_rsp_valid  in  1  ICB response valid.
ifu_icb_rsp_ready  out  1  constant 1; space is reserved at issue.
ifu_icb_rsp_rdata  in  DW  fetched word.
ifu_o_valid  out  1  instruction available to decode.
ifu_o_ready  in  1  decode accepts.
ifu_o_ir  out  DW  instruction word at buffer head.
ifu_o_pc  out  AW  PC of ifu_o_ir.

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC with bits [2:0] cleared.
  - cmd_valid_r, outstanding, squash and buffer count = 0.
  - All outputs low except ifu_icb_cmd_read=1, ifu_icb_rsp_ready=1, ifu_idle=1.
  - ifu_icb_cmd_addr = pc.
  - Reset mid-transaction discards everything; the ITCM is reset in the same domain.
- Addresses are always 8-byte aligned. PC increment is +8, modulo 2^AW; wraps to 0 silently.
- Registered command:
  - ifu_icb_cmd_valid is register cmd_valid_r; ifu_icb_cmd_addr is register cmd_addr_r.
  - Once valid is high, valid and addr hold unchanged until cmd handshake, even across redirect or halt.
- Issue condition, evaluated each cycle: !cmd_valid_r & !outstanding & !fetch_halt & !redirect_valid & (count + 0) < 2.
  - Count is updated for a same-cycle pop, not for a same-cycle push.
  - On issue: cmd_valid_r <= 1, cmd_addr_r <= pc. Valid is visible the cycle after the condition holds.
- Command handshake (valid & ready):
  - cmd_valid_r <= 0, outstanding <= 1, rsp_pc <= cmd_addr_r.
  - pc <= pc + 8, unless redirect is asserted in the same cycle.
- Response handshake (rsp_valid, ready always 1):
  - outstanding <= 0.
  - If squash=1: drop the data and clear squash.
  - Otherwise push {rsp_pc, rdata} into the buffer.
  - A response with outstanding=0 is illegal; assertion only.
- Throughput: at most one transaction in flight, pending or accepted. With a 1-cycle ITCM the sequence is: issue cycle N, handshake N+1, response N+2, next issue N+3.
- Instruction buffer:
  - 2-entry FIFO; ifu_o_valid = (count != 0); head drives ifu_o_ir and ifu_o_pc.
  - Pop on o_valid & o_ready. Push and pop may occur in the same cycle.
  - Overflow is impossible by construction; issue requires free space.
- Redirect (redirect_valid=1):
  - pc <= redirect_pc with [2:0] cleared; buffer flushed (count <= 0). Flush wins over a same-cycle pop or push.
  - squash <= cmd_valid_r | (outstanding & !rsp_handshake), so a pending or accepted stale command's response is dropped.
  - A response arriving in the redirect cycle is discarded.
  - No issue occurs in the redirect cycle; the first fetch from the new PC is raised in the next cycle if the issue condition holds.
  - Back-to-back redirects: the last one wins; squash remains at most 1 because at most one transaction is in flight.
- fetch_halt: blocks only new issue. A pending command and an outstanding response complete normally and are pushed unless squashed.
- ifu_idle = !cmd_valid_r & !outstanding; combinational from registers.

Test Plan:
- Reset with RESET_PC=0x0100, cmd_ready=1, ITCM 1-cycle, decode ready=1 -> command addresses 0x0100, 0x0108, 0x0110 on successive issues. Outputs show ifu_o_pc 0x0100/ir=rdata in order, one instruction per 3 cycles.
- Hold ifu_o_ready=0 -> exactly 2 words buffered and no third command raised. Release ready -> both drained in order, then fetch resumes at 0x0110.
- Raise redirect_valid with redirect_pc=0x0A0C while a command is accepted but the response is pending -> stale response dropped, buffer empty. Next command addr = 0x0A08, and its instruction is delivered with pc=0x0A08.
- Redirect while cmd_valid=1 and cmd_ready=0 for 3 cycles -> cmd_addr holds the old address until handshake. Its response is squashed and the next command addr is the redirect target.
- Assert fetch_halt mid-stream -> in-flight word delivered, no further commands, ifu_idle=1 within 2 cycles after the response. Deassert -> fetch continues at the next sequential PC.
- With AW=16 and pc=0xFFF8 -> next command addr is 0x0000. Assert rst_n low mid-transaction -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/qpu_ifu_fetch_if.sv
// Fetch-side bus bundle: ICB command/response channel to the ITCM plus the
// instruction handoff to decode. master = IFU, slave = ITCM/decode side.
interface qpu_ifu_fetch_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 64,
  parameter int unsigned MW = 8
);
  logic          ifu_icb_cmd_valid;
  logic          ifu_icb_cmd_ready;
  logic [AW-1:0] ifu_icb_cmd_addr;
  logic          ifu_icb_cmd_read;
  logic [DW-1:0] ifu_icb_cmd_wdata;
  logic [MW-1:0] ifu_icb_cmd_wmask;
  logic          ifu_icb_rsp_valid;
  logic          ifu_icb_rsp_ready;
  logic [DW-1:0] ifu_icb_rsp_rdata;
  logic          ifu_o_valid;
  logic          ifu_o_ready;
  logic [DW-1:0] ifu_o_ir;
  logic [AW-1:0] ifu_o_pc;

  modport master (
    output ifu_icb_cmd_valid, ifu_icb_cmd_addr, ifu_icb_cmd_read,
           ifu_icb_cmd_wdata, ifu_icb_cmd_wmask, ifu_icb_rsp_ready,
           ifu_o_valid, ifu_o_ir, ifu_o_pc,
    input  ifu_icb_cmd_ready, ifu_icb_rsp_valid, ifu_icb_rsp_rdata, ifu_o_ready
  );

  modport slave (
    input  ifu_icb_cmd_valid, ifu_icb_cmd_addr, ifu_icb_cmd_read,
           ifu_icb_cmd_wdata, ifu_icb_cmd_wmask, ifu_icb_rsp_ready,
           ifu_o_valid, ifu_o_ir, ifu_o_pc,
    output ifu_icb_cmd_ready, ifu_icb_rsp_valid, ifu_icb_rsp_rdata, ifu_o_ready
  );
endinterface

// File: rtl/qpu_ifu_fetch.sv
// QPU IFU fetch front-end: single-outstanding ICB reads from the ITCM into a
// 2-entry PC-tagged instruction buffer, with redirect/squash and halt.
module qpu_ifu_fetch #(
  parameter int unsigned   AW       = 16,
  parameter int unsigned   DW       = 64,
  parameter int unsigned   MW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [AW-1:0]   redirect_pc,
  input  logic            fetch_halt,
  output logic            ifu_idle,
  qpu_ifu_fetch_if.master bus
);

  localparam logic [AW-1:0] RST_PC = RESET_PC & ~AW'(7);

  logic          cmd_valid_r;
  logic [AW-1:0] cmd_addr_r;
  logic          outstanding;
  logic          squash;
  logic [AW-1:0] pc;
  logic [AW-1:0] rsp_pc;

  logic [AW-1:0] buf_pc [2];
  logic [DW-1:0] buf_ir [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;

  logic          buf_valid;
  logic          cmd_hs;
  logic          rsp_hs;
  logic          push;
  logic          pop;
  logic          issue;
  logic [1:0]    count_after_pop;
  logic          unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[2:0];

  // Handshakes and issue decision; free space accounts for a same-cycle pop only.
  always_comb begin
    buf_valid       = (count != 2'd0);
    cmd_hs          = cmd_valid_r & bus.ifu_icb_cmd_ready;
    rsp_hs          = bus.ifu_icb_rsp_valid;
    push            = rsp_hs & ~squash;
    pop             = buf_valid & bus.ifu_o_ready;
    count_after_pop = count - 2'(pop);
    issue           = ~cmd_valid_r & ~outstanding & ~fetch_halt & ~redirect_valid
                      & (count_after_pop < 2'd2);
  end

  // Fetch PC, command register and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RST_PC;
      cmd_valid_r <= 1'b0;
      cmd_addr_r  <= RST_PC;
      outstanding <= 1'b0;
      squash      <= 1'b0;
      rsp_pc      <= '0;
    end else begin
      if (cmd_hs) begin
        cmd_valid_r <= 1'b0;
        outstanding <= 1'b1;
        rsp_pc      <= cmd_addr_r;
      end else if (issue) begin
        cmd_valid_r <= 1'b1;
        cmd_addr_r  <= pc;
      end
      if (rsp_hs) outstanding <= 1'b0;
      // A stale (squashed) command must not advance the PC past the redirect target.
      if (redirect_valid) begin
        pc     <= {redirect_pc[AW-1:3], 3'b000};
        squash <= cmd_valid_r | (outstanding & ~rsp_hs);
      end else begin
        if (cmd_hs && !squash) pc <= pc + AW'(8);
        if (rsp_hs) squash <= 1'b0;
      end
    end
  end

  // Instruction buffer; a redirect flush takes priority over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_pc[i] <= '0;
        buf_ir[i] <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        buf_pc[wr_ptr] <= rsp_pc;
        buf_ir[wr_ptr] <= bus.ifu_icb_rsp_rdata;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign bus.ifu_icb_cmd_valid = cmd_valid_r;
  assign bus.ifu_icb_cmd_addr  = cmd_addr_r;
  assign bus.ifu_icb_cmd_read  = 1'b1;
  assign bus.ifu_icb_cmd_wdata = DW'(0);
  assign bus.ifu_icb_cmd_wmask = MW'(0);
  assign bus.ifu_icb_rsp_ready = 1'b1;
  assign bus.ifu_o_valid       = buf_valid;
  assign bus.ifu_o_ir          = buf_ir[rd_ptr];
  assign bus.ifu_o_pc          = buf_pc[rd_ptr];
  assign ifu_idle              = ~cmd_valid_r & ~outstanding;

  // A response is only legal while a command is outstanding.
  rsp_legal: assert property (@(posedge clk) disable iff (!rst_n)
                              !(bus.ifu_icb_rsp_valid && !outstanding));

endmodule

// File: tb/tb_qpu_ifu_fetch.sv
// Bench for qpu_ifu_fetch: directed scenarios plus random traffic, checked
// against a transaction-level fetch model and a behavioural ITCM.
module tb_qpu_ifu_fetch;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = 8;
  localparam int unsigned CW = AW + DW;
  localparam logic [AW-1:0] RPC = 16'h0100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          fetch_halt;
  logic          ifu_idle;

  qpu_ifu_fetch_if #(.AW(AW), .DW(DW), .MW(MW)) bus ();

  qpu_ifu_fetch #(.AW(AW), .DW(DW), .MW(MW), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_halt     (fetch_halt),
    .ifu_idle       (ifu_idle),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int lat   = 1;
  logic [63:0] seed;

  // Model state: expected buffer contents, current transaction, next fetch PC.
  logic [CW-1:0] exp_q [$];
  logic [AW-1:0] raise_q [$];
  int            raise_cyc [$];
  logic [AW-1:0] pop_q [$];
  logic          inflight, stale, hold_exp, expect_raise;
  logic [AW-1:0] exp_next, held_addr, txn_exp;
  logic          itcm_pend;
  int            itcm_cnt;
  logic [AW-1:0] itcm_addr;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] h;
    h = {a, ~a} * 32'h9E37_79B1;
    return {h, a, ~a} ^ seed;
  endfunction

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    inflight     = 1'b0;
    stale        = 1'b0;
    hold_exp     = 1'b0;
    expect_raise = 1'b0;
    exp_next     = RPC & ~16'h0007;
    itcm_pend    = 1'b0;
    itcm_cnt     = 0;
    bus.ifu_icb_rsp_valid = 1'b0;
    bus.ifu_icb_rsp_rdata = '0;
  endtask

  task automatic reset_checks(input string p);
    chk({p, "_cmd_valid"}, CW'(bus.ifu_icb_cmd_valid), CW'(1'b0));
    chk({p, "_cmd_addr"},  CW'(bus.ifu_icb_cmd_addr),  CW'(16'h0100));
    chk({p, "_cmd_read"},  CW'(bus.ifu_icb_cmd_read),  CW'(1'b1));
    chk({p, "_wdata"},     CW'(bus.ifu_icb_cmd_wdata), CW'(64'h0));
    chk({p, "_wmask"},     CW'(bus.ifu_icb_cmd_wmask), CW'(8'h0));
    chk({p, "_rsp_ready"}, CW'(bus.ifu_icb_rsp_ready), CW'(1'b1));
    chk({p, "_o_valid"},   CW'(bus.ifu_o_valid),       CW'(1'b0));
    chk({p, "_o_ir"},      CW'(bus.ifu_o_ir),          CW'(64'h0));
    chk({p, "_o_pc"},      CW'(bus.ifu_o_pc),          CW'(16'h0));
    chk({p, "_idle"},      CW'(ifu_idle),              CW'(1'b1));
  endtask

  // One clock: check outputs against the model, account for the handshakes at
  // the coming edge, then drive the ITCM response for the next cycle.
  task automatic step();
    logic c_hs, o_hs, r_hs, rd, stale_set;
    logic [CW-1:0] head;
    #1;
    chk("o_valid", CW'(bus.ifu_o_valid), CW'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      chk("o_pc", CW'(bus.ifu_o_pc), CW'(head[CW-1:DW]));
      chk("o_ir", CW'(bus.ifu_o_ir), CW'(head[DW-1:0]));
    end
    chk("idle", CW'(ifu_idle), CW'(!bus.ifu_icb_cmd_valid && !inflight));
    if (hold_exp) begin
      chk("cmd_hold_valid", CW'(bus.ifu_icb_cmd_valid), CW'(1'b1));
      chk("cmd_hold_addr", CW'(bus.ifu_icb_cmd_addr), CW'(held_addr));
    end else begin
      chk("cmd_issue", CW'(bus.ifu_icb_cmd_valid), CW'(expect_raise));
      if (bus.ifu_icb_cmd_valid) begin
        chk("cmd_addr", CW'(bus.ifu_icb_cmd_addr), CW'(exp_next));
        held_addr = bus.ifu_icb_cmd_addr;
        txn_exp   = exp_next;
        stale     = 1'b0;
        raise_q.push_back(held_addr);
        raise_cyc.push_back(cyc);
      end
    end

    c_hs = bus.ifu_icb_cmd_valid & bus.ifu_icb_cmd_ready;
    o_hs = bus.ifu_o_valid & bus.ifu_o_ready;
    r_hs = bus.ifu_icb_rsp_valid;
    rd   = redirect_valid;
    stale_set    = rd && (bus.ifu_icb_cmd_valid || (inflight && !r_hs));
    expect_raise = !bus.ifu_icb_cmd_valid && !inflight && !fetch_halt && !rd &&
                   ((exp_q.size() - int'(o_hs)) < 2);
    hold_exp     = bus.ifu_icb_cmd_valid && !c_hs;

    if (o_hs && !rd) pop_q.push_back(bus.ifu_o_pc);
    if (o_hs && exp_q.size() != 0) void'(exp_q.pop_front());
    if (r_hs) begin
      if (!rd && !stale) exp_q.push_back({txn_exp, mem_word(txn_exp)});
      inflight = 1'b0;
    end
    if (c_hs) begin
      inflight  = 1'b1;
      if (!rd && !stale) exp_next = txn_exp + 16'd8;
      itcm_pend = 1'b1;
      itcm_cnt  = lat;
      itcm_addr = bus.ifu_icb_cmd_addr;
    end
    if (rd) begin
      exp_q.delete();
      exp_next = {redirect_pc[AW-1:3], 3'b000};
      if (stale_set) stale = 1'b1;
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;
    bus.ifu_icb_rsp_valid = 1'b0;
    bus.ifu_icb_rsp_rdata = {$urandom, $urandom};
    if (itcm_pend) begin
      itcm_cnt--;
      if (itcm_cnt == 0) begin
        bus.ifu_icb_rsp_valid = 1'b1;
        bus.ifu_icb_rsp_rdata = mem_word(itcm_addr);
        itcm_pend = 1'b0;
      end
    end
  endtask

  task automatic redirect_to(input logic [AW-1:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int n, rn, pn;
    logic [AW-1:0] a;
    seed = {$urandom, $urandom};
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fetch_halt     = 1'b0;
    bus.ifu_icb_cmd_ready = 1'b0;
    bus.ifu_o_ready       = 1'b0;
    reset_model();
    @(negedge clk);
    @(negedge clk);
    reset_checks("rst");
    rst_n = 1'b1;

    // Sequential fetch, 1-cycle ITCM, decode always ready.
    bus.ifu_icb_cmd_ready = 1'b1;
    bus.ifu_o_ready       = 1'b1;
    lat = 1;
    n = 0;
    while (raise_q.size() < 3 && n < 40) begin step(); n++; end
    chk("seq_timeout", CW'(n < 40), CW'(1'b1));
    chk("seq_addr0", CW'(raise_q[0]), CW'(16'h0100));
    chk("seq_addr1", CW'(raise_q[1]), CW'(16'h0108));
    chk("seq_addr2", CW'(raise_q[2]), CW'(16'h0110));
    chk("seq_rate", CW'(raise_cyc[1] - raise_cyc[0]), CW'(3));
    chk("seq_rate2", CW'(raise_cyc[2] - raise_cyc[1]), CW'(3));
    n = 0;
    while (pop_q.size() < 1 && n < 20) begin step(); n++; end
    chk("seq_first_pc", CW'(pop_q[0]), CW'(16'h0100));

    // Decode stalled: buffer fills to two, no third command.
    bus.ifu_o_ready = 1'b0;
    repeat (15) step();
    chk("full_no_cmd", CW'(bus.ifu_icb_cmd_valid), CW'(1'b0));
    chk("full_idle", CW'(ifu_idle), CW'(1'b1));
    chk("full_depth", CW'(exp_q.size()), CW'(2));
    a  = raise_q[raise_q.size()-1];
    rn = raise_q.size();
    bus.ifu_o_ready = 1'b1;
    n = 0;
    while (raise_q.size() <= rn && n < 20) begin step(); n++; end
    chk("resume_addr", CW'(raise_q[rn]), CW'(a + 16'd8));

    // Redirect while a command is accepted and its response is pending.
    lat = 3;
    n = 0;
    while (!(inflight && !bus.ifu_icb_rsp_valid) && n < 40) begin step(); n++; end
    chk("redir_wait", CW'(n < 40), CW'(1'b1));
    rn = raise_q.size();
    pn = pop_q.size();
    redirect_to(16'h0A0C);
    chk("redir_flush", CW'(bus.ifu_o_valid), CW'(1'b0));
    n = 0;
    while (pop_q.size() <= pn && n < 40) begin step(); n++; end
    chk("redir_cmd", CW'(raise_q[rn]), CW'(16'h0A08));
    chk("redir_deliver", CW'(pop_q[pn]), CW'(16'h0A08));

    // Redirect while a command waits for cmd_ready.
    lat = 1;
    bus.ifu_icb_cmd_ready = 1'b0;
    n = 0;
    while (!bus.ifu_icb_cmd_valid && n < 20) begin step(); n++; end
    a = bus.ifu_icb_cmd_addr;
    redirect_to(16'h0C00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pend_hold_addr", CW'(bus.ifu_icb_cmd_addr), CW'(a));
    end
    rn = raise_q.size();
    pn = pop_q.size();
    bus.ifu_icb_cmd_ready = 1'b1;
    n = 0;
    while (pop_q.size() <= pn && n < 40) begin step(); n++; end
    chk("pend_cmd", CW'(raise_q[rn]), CW'(16'h0C00));
    chk("pend_deliver", CW'(pop_q[pn]), CW'(16'h0C00));

    // Halt with a transaction in flight.
    lat = 2;
    n = 0;
    while (!inflight && n < 20) begin step(); n++; end
    fetch_halt = 1'b1;
    a  = raise_q[raise_q.size()-1];
    rn = raise_q.size();
    pn = pop_q.size();
    n = 0;
    while (inflight && n < 20) begin step(); n++; end
    chk("halt_idle", CW'(ifu_idle), CW'(1'b1));
    repeat (10) step();
    chk("halt_no_cmd", CW'(raise_q.size()), CW'(rn));
    chk("halt_delivered", CW'(pop_q.size()), CW'(pn + 1));
    chk("halt_word_pc", CW'(pop_q[pn]), CW'(a));
    fetch_halt = 1'b0;
    n = 0;
    while (raise_q.size() <= rn && n < 20) begin step(); n++; end
    chk("halt_resume", CW'(raise_q[rn]), CW'(a + 16'd8));

    // PC wrap at the top of the address space.
    lat = 1;
    redirect_to(16'hFFF8);
    rn = raise_q.size();
    n = 0;
    while (raise_q.size() < rn + 2 && n < 40) begin step(); n++; end
    chk("wrap_top", CW'(raise_q[rn]), CW'(16'hFFF8));
    chk("wrap_zero", CW'(raise_q[rn+1]), CW'(16'h0000));

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      bus.ifu_icb_cmd_ready = ($urandom_range(0, 3) != 0);
      bus.ifu_o_ready       = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) fetch_halt = ~fetch_halt;
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = 16'($urandom);
      lat            = $urandom_range(1, 3);
      step();
    end
    redirect_valid = 1'b0;
    fetch_halt     = 1'b0;
    bus.ifu_icb_cmd_ready = 1'b1;
    bus.ifu_o_ready       = 1'b1;
    repeat (20) step();

    // Reset in the middle of a transaction with a word buffered.
    lat = 3;
    bus.ifu_o_ready = 1'b0;
    n = 0;
    while (!(bus.ifu_o_valid && inflight) && n < 40) begin step(); n++; end
    chk("midrst_wait", CW'(n < 40), CW'(1'b1));
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    reset_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.ifu_o_ready = 1'b1;
    rn = raise_q.size();
    n = 0;
    while (raise_q.size() <= rn && n < 20) begin step(); n++; end
    chk("midrst_restart", CW'(raise_q[rn]), CW'(16'h0100));
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
